// File: rtl/ts_packet_arbiter_if.sv
// rtl/ts_packet_arbiter_if.sv - stream bundle between the sync recovery stage and the packet arbiter
//
// Purpose: groups the four input byte lanes, the merged output stream and the
//          per-channel drop counters of ts_packet_arbiter.
// Signals:
//   ts_in[31:0]   4 byte lanes, channel i = ts_in[8*i+7:8*i]
//   valid_in[3:0] per-lane byte valid
//   sync_in[3:0]  per-lane packet-start flag (meaningful with valid_in)
//   chan_en[3:0]  channel enable mask
//   drop_clr      clear of all drop counters
//   byte_out      forwarded byte
//   valid_out     byte_out valid
//   sync_out      first byte of a forwarded packet
//   chan_out      source channel of byte_out
//   pkt_err       one-cycle pulse on packet abort
//   drop_cnt      4 saturating drop counters, DROP_W bits each
interface ts_packet_arbiter_if #(
  parameter int DROP_W = 8
);
  logic [31:0]         ts_in;
  logic [3:0]          valid_in;
  logic [3:0]          sync_in;
  logic [3:0]          chan_en;
  logic                drop_clr;
  logic [7:0]          byte_out;
  logic                valid_out;
  logic                sync_out;
  logic [1:0]          chan_out;
  logic                pkt_err;
  logic [4*DROP_W-1:0] drop_cnt;

  modport master (
    output ts_in, valid_in, sync_in, chan_en, drop_clr,
    input  byte_out, valid_out, sync_out, chan_out, pkt_err, drop_cnt
  );

  modport slave (
    input  ts_in, valid_in, sync_in, chan_en, drop_clr,
    output byte_out, valid_out, sync_out, chan_out, pkt_err, drop_cnt
  );
endinterface

// File: rtl/ts_packet_arbiter.sv
// rtl/ts_packet_arbiter.sv - packet-granular round-robin merge of four TS byte streams
//
// Purpose: grants one channel at a packet start (sync byte), forwards exactly
//          PKT_LEN bytes from it, and counts starts on other enabled channels
//          that arrive while busy or lose the grant.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  ts_packet_arbiter_if.slave (input lanes, merged output, drop counters)
module ts_packet_arbiter #(
  parameter int PKT_LEN = 188,
  parameter int TIMEOUT = 1024,
  parameter int DROP_W  = 8
) (
  input logic               clk,
  input logic               rst,
  ts_packet_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FWD  = 1'b1;

  localparam logic [7:0]        PKT_LEN_B = 8'(PKT_LEN);
  localparam logic [15:0]       IDLE_MAX  = 16'(TIMEOUT - 1);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1);

  logic [0:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       idle_cnt_q, idle_cnt_d;
  logic [DROP_W-1:0] drop_q [4];

  logic [7:0] byte_out_q, byte_out_d;
  logic       valid_out_q, valid_out_d;
  logic       sync_out_q, sync_out_d;
  logic [1:0] chan_out_q, chan_out_d;
  logic       pkt_err_q, pkt_err_d;

  logic [3:0] start, cand, inc;
  logic [1:0] sel, idx;
  logic       found;
  logic [7:0] sel_byte, g_byte;

  assign start    = bus.valid_in & bus.sync_in;
  assign cand     = start & bus.chan_en;
  assign sel_byte = bus.ts_in[{sel, 3'b000} +: 8];
  assign g_byte   = bus.ts_in[{grant_q, 3'b000} +: 8];

  // Round-robin pick: first candidate at or after rr_ptr, wrapping mod 4.
  always_comb begin
    sel   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    byte_out_d  = 8'd0;
    valid_out_d = 1'b0;
    sync_out_d  = 1'b0;
    chan_out_d  = 2'd0;
    pkt_err_d   = 1'b0;
    inc         = 4'd0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          grant_d     = sel;
          byte_out_d  = sel_byte;
          valid_out_d = 1'b1;
          sync_out_d  = 1'b1;
          chan_out_d  = sel;
          byte_cnt_d  = 8'd1;
          idle_cnt_d  = 16'd0;
          state_d     = FWD;
          inc         = cand & ~(4'b0001 << sel);
        end
      end
      FWD: begin
        // Losing starts are counted on every FWD cycle, including the last byte.
        inc = cand & ~(4'b0001 << grant_q);
        if (bus.valid_in[grant_q]) begin
          idle_cnt_d = 16'd0;
          if (bus.sync_in[grant_q]) begin
            // Truncated packet: drop the new sync byte, it is not re-arbitrated.
            pkt_err_d = 1'b1;
            state_d   = IDLE;
            rr_ptr_d  = grant_q + 2'd1;
          end else begin
            byte_out_d  = g_byte;
            valid_out_d = 1'b1;
            chan_out_d  = grant_q;
            byte_cnt_d  = byte_cnt_q + 8'd1;
            if (byte_cnt_q + 8'd1 == PKT_LEN_B) begin
              state_d  = IDLE;
              rr_ptr_d = grant_q + 2'd1;
            end
          end
        end else if (idle_cnt_q == IDLE_MAX) begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
          rr_ptr_d  = grant_q + 2'd1;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      byte_cnt_q  <= 8'd0;
      idle_cnt_q  <= 16'd0;
      byte_out_q  <= 8'd0;
      valid_out_q <= 1'b0;
      sync_out_q  <= 1'b0;
      chan_out_q  <= 2'd0;
      pkt_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) drop_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      byte_out_q  <= byte_out_d;
      valid_out_q <= valid_out_d;
      sync_out_q  <= sync_out_d;
      chan_out_q  <= chan_out_d;
      pkt_err_q   <= pkt_err_d;
      // Clear wins over a same-cycle increment; counters saturate.
      for (int i = 0; i < 4; i++) begin
        if (bus.drop_clr) drop_q[i] <= '0;
        else if (inc[i] && drop_q[i] != DROP_MAX) drop_q[i] <= drop_q[i] + DROP_ONE;
      end
    end
  end

  assign bus.byte_out  = byte_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.sync_out  = sync_out_q;
  assign bus.chan_out  = chan_out_q;
  assign bus.pkt_err   = pkt_err_q;

  for (genvar i = 0; i < 4; i++) begin : g_drop
    assign bus.drop_cnt[DROP_W*i +: DROP_W] = drop_q[i];
  end

endmodule

// File: tb/tb_ts_packet_arbiter.sv
// tb/tb_ts_packet_arbiter.sv - directed self-checking bench for ts_packet_arbiter
module tb_ts_packet_arbiter;

  localparam int PKT_LEN = 188;
  localparam int TIMEOUT = 1024;
  localparam int DROP_W  = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ts_packet_arbiter_if #(.DROP_W(DROP_W)) bus ();

  ts_packet_arbiter #(
    .PKT_LEN(PKT_LEN),
    .TIMEOUT(TIMEOUT),
    .DROP_W (DROP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.ts_in    = 32'd0;
    bus.valid_in = 4'd0;
    bus.sync_in  = 4'd0;
  endtask

  task automatic set_in(input int ch, input logic [7:0] b, input logic v, input logic s);
    bus.ts_in[8*ch +: 8] = b;
    bus.valid_in[ch]     = v;
    bus.sync_in[ch]      = s;
  endtask

  // {pkt_err, valid_out, sync_out, chan_out, byte_out}
  function automatic logic [31:0] out_w();
    return {19'd0, bus.pkt_err, bus.valid_out, bus.sync_out, bus.chan_out, bus.byte_out};
  endfunction

  function automatic logic [31:0] exp_w(input logic s, input int ch, input logic [7:0] b);
    logic [1:0] c;
    c = 2'(ch);
    return {19'd0, 1'b0, 1'b1, s, c, b};
  endfunction

  function automatic logic [31:0] drop(input int ch);
    return {24'd0, bus.drop_cnt[DROP_W*ch +: DROP_W]};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    clr_in();
    bus.drop_clr = 1'b0;
    #1;
    check("rst_out", out_w(), 32'd0);
    check("rst_drop", bus.drop_cnt, 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Single start byte on ch; expect it granted with sync_out.
  task automatic send_start(input int ch, input string tag);
    clr_in();
    set_in(ch, 8'h47, 1'b1, 1'b1);
    cyc();
    check(tag, out_w(), exp_w(1'b1, ch, 8'h47));
  endtask

  // Body bytes k=1..last_k carry value k-1. A gap cycle precedes every byte
  // with k%gap==0 when gap>0. inj_ch>=0 adds a start on that lane when k%50==0.
  task automatic send_body(input int ch, input int last_k, input int gap, input int inj_ch);
    for (int k = 1; k <= last_k; k++) begin
      if (gap > 0 && (k % gap) == 0) begin
        clr_in();
        cyc();
        check("gap_idle", out_w(), 32'd0);
      end
      clr_in();
      set_in(ch, 8'(k - 1), 1'b1, 1'b0);
      if (inj_ch >= 0 && (k % 50) == 0) set_in(inj_ch, 8'h47, 1'b1, 1'b1);
      cyc();
      check("body_byte", out_w(), exp_w(1'b0, ch, 8'(k - 1)));
    end
    clr_in();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    clr_in();
    bus.chan_en  = 4'hF;
    bus.drop_clr = 1'b0;

    // 1: single ch1 packet with gaps
    do_reset();
    send_start(1, "t1_start");
    send_body(1, PKT_LEN - 1, 7, -1);
    cyc();
    check("t1_after", out_w(), 32'd0);

    // 2: simultaneous starts, round-robin rotation
    do_reset();
    set_in(0, 8'h47, 1'b1, 1'b1);
    set_in(2, 8'h47, 1'b1, 1'b1);
    cyc();
    check("t2_grant0", out_w(), exp_w(1'b1, 0, 8'h47));
    check("t2_drop2", drop(2), 32'd1);
    send_body(0, PKT_LEN - 1, 0, -1);
    set_in(0, 8'h47, 1'b1, 1'b1);
    set_in(2, 8'h47, 1'b1, 1'b1);
    cyc();
    check("t2_grant2", out_w(), exp_w(1'b1, 2, 8'h47));
    check("t2_drop0", drop(0), 32'd1);
    send_body(2, PKT_LEN - 1, 0, -1);

    // 3: ch1 starts during a ch3 packet are dropped
    send_start(3, "t3_start");
    send_body(3, PKT_LEN - 1, 0, 1);
    check("t3_drop1", drop(1), 32'd3);
    cyc();
    check("t3_after", out_w(), 32'd0);

    // 4a: truncated ch2 packet at byte 100
    send_start(2, "t4_start");
    send_body(2, 98, 0, -1);
    set_in(2, 8'h47, 1'b1, 1'b1);
    cyc();
    check("t4_trunc", out_w(), 32'h1000);
    clr_in();
    cyc();
    check("t4_err_once", out_w(), 32'd0);
    // 4b: stall after byte 50 until timeout
    send_start(2, "t4_idle_start");
    send_body(2, 49, 0, -1);
    for (int t = 1; t <= TIMEOUT; t++) begin
      cyc();
      if (t == TIMEOUT - 1) check("t4_no_early_err", out_w(), 32'd0);
      if (t == TIMEOUT)     check("t4_timeout", out_w(), 32'h1000);
    end
    cyc();
    check("t4_err_clear", out_w(), 32'd0);
    set_in(2, 8'h31, 1'b1, 1'b0);
    cyc();
    check("t4_no_output", out_w(), 32'd0);
    clr_in();

    // 5: enable mask and saturation
    do_reset();
    bus.chan_en = 4'b0001;
    for (int c = 0; c < 4; c++) set_in(c, 8'h47, 1'b1, 1'b1);
    cyc();
    check("t5_grant0", out_w(), exp_w(1'b1, 0, 8'h47));
    send_body(0, PKT_LEN - 1, 0, -1);
    check("t5_no_drops", bus.drop_cnt, 32'd0);
    bus.chan_en = 4'hF;
    send_start(1, "t5_grant1");
    for (int t = 1; t <= 300; t++) begin
      clr_in();
      set_in(0, 8'h47, 1'b1, 1'b1);
      cyc();
      if (t == 254) check("t5_drop254", drop(0), 32'd254);
    end
    check("t5_sat", drop(0), 32'd255);
    bus.drop_clr = 1'b1;
    cyc();
    check("t5_clr_prio", drop(0), 32'd0);
    bus.drop_clr = 1'b0;
    cyc();
    check("t5_inc_after_clr", drop(0), 32'd1);
    send_body(1, PKT_LEN - 1, 0, -1);

    // 6: reset mid-packet
    send_start(3, "t6_start");
    send_body(3, 59, 0, -1);
    set_in(3, 8'd59, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("t6_rst_out", out_w(), 32'd0);
    check("t6_rst_drop", bus.drop_cnt, 32'd0);
    clr_in();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check("t6_no_err", out_w(), 32'd0);
    for (int c = 0; c < 4; c++) set_in(c, 8'h47, 1'b1, 1'b1);
    cyc();
    check("t6_grant0", out_w(), exp_w(1'b1, 0, 8'h47));
    check("t6_drops", bus.drop_cnt, 32'h01010100);
    clr_in();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
